bcrypt_hash_encoder: RTL

//  Streaming bcrypt result formatter. Sits after the cipher core, in place of output-side hash packing.

---
 rtl/bcrypt_pkg.sv | 25 ++
 rtl/bcrypt_b64_lut.sv | 16 +
 rtl/bcrypt_hash_encoder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcrypt_pkg.sv
// Shared constants, character-count helpers and FSM state type for the bcrypt
// modular-crypt string formatter.
package bcrypt_pkg;

  localparam logic [8*64-1:0] B64_ALPHABET =
    "./ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";

  // Characters needed to carry nbytes at 6 bits per character, rounded up.
  function automatic int unsigned b64_chars(input int unsigned nbytes);
    return (8 * nbytes + 5) / 6;
  endfunction

  function automatic int unsigned total_chars(input int unsigned salt_bytes,
                                              input int unsigned hash_bytes);
    return 7 + b64_chars(salt_bytes) + b64_chars(hash_bytes);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/bcrypt_b64_lut.sv
// bcrypt base64 digit: 6-bit sextet to ASCII character, purely combinational.
module bcrypt_b64_lut
  import bcrypt_pkg::*;
(
  input  logic [5:0] i_sx,
  output logic [7:0] o_char_c
);

  always_comb begin
    o_char_c = 8'h00;
    for (int k = 0; k < 64; k++) begin
      if (i_sx == 6'(k)) o_char_c = B64_ALPHABET[8*(63-k) +: 8];
    end
  end

endmodule

// File: rtl/bcrypt_hash_encoder.sv
// Streaming bcrypt result formatter: captures cost/salt/ciphertext and emits
// "$2<V>$NN$<salt><hash>" as ASCII over a valid/ready multi-lane byte stream.
module bcrypt_hash_encoder
  import bcrypt_pkg::*;
#(
  parameter int unsigned NUM_CT_WORDS = 6,
  parameter int unsigned HASH_BYTES   = 23,
  parameter int unsigned SALT_BYTES   = 16,
  parameter int unsigned LANES        = 1,
  parameter logic [7:0]  VARIANT      = 8'h61
) (
  input  logic                      clk,
  input  logic                      int_rst_l,
  input  logic                      start,
  input  logic [5:0]                cost,
  input  logic [8*SALT_BYTES-1:0]   salt,
  input  logic [32*NUM_CT_WORDS-1:0] ct,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [8*LANES-1:0]        out_data,
  output logic [LANES-1:0]          out_keep,
  output logic                      out_last,
  output logic                      done,
  output logic                      err_cost
);

  localparam int unsigned SC        = b64_chars(SALT_BYTES);
  localparam int unsigned HC        = b64_chars(HASH_BYTES);
  localparam int unsigned TOTAL     = total_chars(SALT_BYTES, HASH_BYTES);
  localparam int unsigned BEATS     = (TOTAL + LANES - 1) / LANES;
  localparam int unsigned LAST_BASE = (BEATS - 1) * LANES;
  localparam int unsigned IDX_W     = $clog2(TOTAL + LANES);
  localparam int unsigned SALT_W    = 8 * SALT_BYTES;
  localparam int unsigned SALT_PW   = 6 * SC;
  localparam int unsigned HASH_W    = 8 * HASH_BYTES;
  localparam int unsigned HASH_PW   = 6 * HC;
  localparam int unsigned CT_W      = 32 * NUM_CT_WORDS;

  state_e               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic                 r_out_valid, w_valid_nxt;
  logic [8*LANES-1:0]   r_out_data, w_data_nxt;
  logic [LANES-1:0]     r_out_keep, w_keep_nxt;
  logic                 r_out_last, w_last_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_err_cost, w_err_nxt;
  logic                 w_cap;
  logic                 w_cost_ok;

  logic [5:0]           r_cost;
  logic [SALT_PW-1:0]   r_salt_bits;
  logic [HASH_PW-1:0]   r_hash_bits;

  logic [IDX_W-1:0]     w_base;
  logic [8*LANES-1:0]   w_beat_data;
  logic [LANES-1:0]     w_beat_keep;
  logic                 w_beat_last;

  logic [7:0]           w_hdr_ch [7];
  logic [5:0]           w_salt_sx [SC];
  logic [5:0]           w_hash_sx [HC];

  assign w_cost_ok = (cost >= 6'd4) && (cost <= 6'd31);

  // Low ciphertext bytes beyond HASH_BYTES are intentionally dropped.
  if (CT_W > HASH_W) begin : g_ct_tail
    logic w_unused_ct_tail;
    assign w_unused_ct_tail = ^ct[CT_W-HASH_W-1:0];
  end

  // Capture registers; fields are right-padded with zeros to whole sextets.
  always_ff @(posedge clk or negedge int_rst_l) begin
    if (!int_rst_l) begin
      r_cost      <= '0;
      r_salt_bits <= '0;
      r_hash_bits <= '0;
    end else if (w_cap) begin
      r_cost      <= cost;
      r_salt_bits <= SALT_PW'(salt) << (SALT_PW - SALT_W);
      r_hash_bits <= HASH_PW'(ct[CT_W-1 -: HASH_W]) << (HASH_PW - HASH_W);
    end
  end

  assign w_hdr_ch[0] = 8'h24;
  assign w_hdr_ch[1] = 8'h32;
  assign w_hdr_ch[2] = VARIANT;
  assign w_hdr_ch[3] = 8'h24;
  assign w_hdr_ch[4] = 8'h30 + 8'(r_cost / 6'd10);
  assign w_hdr_ch[5] = 8'h30 + 8'(r_cost % 6'd10);
  assign w_hdr_ch[6] = 8'h24;

  for (genvar k = 0; k < SC; k++) begin : g_salt_sx
    assign w_salt_sx[k] = r_salt_bits[SALT_PW-1-6*k -: 6];
  end

  for (genvar k = 0; k < HC; k++) begin : g_hash_sx
    assign w_hash_sx[k] = r_hash_bits[HASH_PW-1-6*k -: 6];
  end

  // Char index of lane 0 for the beat being registered next.
  assign w_base      = (r_state == ST_LOAD) ? '0 : r_idx + IDX_W'(LANES);
  assign w_beat_last = (w_base == IDX_W'(LAST_BASE));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_W-1:0] w_ci;
    logic [5:0]       w_sx;
    logic [7:0]       w_hdr;
    logic             w_is_hdr;
    logic [7:0]       w_b64;

    assign w_ci = w_base + IDX_W'(l);

    always_comb begin
      w_sx     = '0;
      w_hdr    = '0;
      w_is_hdr = 1'b0;
      for (int k = 0; k < 7; k++) begin
        if (w_ci == IDX_W'(k)) begin
          w_is_hdr = 1'b1;
          w_hdr    = w_hdr_ch[k];
        end
      end
      for (int k = 0; k < SC; k++) begin
        if (w_ci == IDX_W'(7 + k)) w_sx = w_salt_sx[k];
      end
      for (int k = 0; k < HC; k++) begin
        if (w_ci == IDX_W'(7 + SC + k)) w_sx = w_hash_sx[k];
      end
    end

    bcrypt_b64_lut u_lut (
      .i_sx     (w_sx),
      .o_char_c (w_b64)
    );

    assign w_beat_keep[l]      = (w_ci < IDX_W'(TOTAL));
    assign w_beat_data[8*l +: 8] = !w_beat_keep[l] ? 8'h00 : (w_is_hdr ? w_hdr : w_b64);
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_out_valid;
    w_data_nxt  = r_out_data;
    w_keep_nxt  = r_out_keep;
    w_last_nxt  = r_out_last;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_cost_ok) begin
            w_cap       = 1'b1;
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        w_idx_nxt   = w_base;
        w_valid_nxt = 1'b1;
        w_data_nxt  = w_beat_data;
        w_keep_nxt  = w_beat_keep;
        w_last_nxt  = w_beat_last;
        w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (r_out_valid && out_ready) begin
          if (r_out_last) begin
            w_valid_nxt = 1'b0;
            w_data_nxt  = '0;
            w_keep_nxt  = '0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_FIN;
          end else begin
            w_idx_nxt  = w_base;
            w_data_nxt = w_beat_data;
            w_keep_nxt = w_beat_keep;
            w_last_nxt = w_beat_last;
          end
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge int_rst_l) begin
    if (!int_rst_l) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_cost  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_data  <= w_data_nxt;
      r_out_keep  <= w_keep_nxt;
      r_out_last  <= w_last_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err_cost  <= w_err_nxt;
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;
  assign done      = r_done;
  assign err_cost  = r_err_cost;

endmodule
